pzcorebus_monitor_window_controller: RTL

Sequences measurement windows for a bank of corebus command counters. It clears the counters, enables them for a programmed number of cycles, then issues a snapshot strobe so software or the bank can latch the counts. It runs single-shot or periodic, and sits beside the command counters in the corebus debug/monitor subsystem, driving their shared enable and clear inputs.

---
 rtl/pzcorebus_monitor_pkg.sv | 14 +
 rtl/pzcorebus_monitor_window_timer.sv | 43 ++++
 rtl/pzcorebus_monitor_window_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pzcorebus_monitor_pkg.sv
// Shared types and default widths for the corebus debug/monitor subsystem.
package pzcorebus_monitor_pkg;

  localparam int unsigned DEFAULT_TIMER_WIDTH        = 32;
  localparam int unsigned DEFAULT_WINDOW_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    WIN_IDLE     = 2'd0,
    WIN_CLEAR    = 2'd1,
    WIN_RUN      = 2'd2,
    WIN_SNAPSHOT = 2'd3
  } pzcorebus_monitor_window_state;

endpackage

// File: rtl/pzcorebus_monitor_window_timer.sv
// Elapsed-cycle timer for one measurement window: latches the window length,
// counts enabled cycles with saturation and flags the last cycle of the window.
module pzcorebus_monitor_window_timer
  import pzcorebus_monitor_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = DEFAULT_TIMER_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [TIMER_WIDTH-1:0] i_window_cycles,
  input  logic                   i_clear,
  input  logic                   i_enable,
  output logic [TIMER_WIDTH-1:0] o_count,
  output logic                   o_terminal_c
);

  localparam logic [TIMER_WIDTH-1:0] COUNT_MAX = '1;

  logic [TIMER_WIDTH-1:0] window_q;
  logic [TIMER_WIDTH-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      window_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_load) begin
        window_q <= i_window_cycles;
      end
      if (i_clear) begin
        count_q <= '0;
      end else if (i_enable && (count_q != COUNT_MAX)) begin
        count_q <= count_q + TIMER_WIDTH'(1);
      end
    end
  end

  // A zero window length is open-ended and never reaches terminal count.
  assign o_terminal_c = (window_q != '0) && (count_q == (window_q - TIMER_WIDTH'(1)));
  assign o_count      = count_q;

endmodule

// File: rtl/pzcorebus_monitor_window_controller.sv
// Sequences clear / enable / snapshot windows for a bank of corebus command
// counters, single-shot or periodic, with early stop.
module pzcorebus_monitor_window_controller
  import pzcorebus_monitor_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH        = DEFAULT_TIMER_WIDTH,
  parameter int unsigned WINDOW_COUNT_WIDTH = DEFAULT_WINDOW_COUNT_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_periodic,
  input  logic [TIMER_WIDTH-1:0]        i_window_cycles,
  output logic                          o_clear,
  output logic                          o_enable,
  output logic                          o_snapshot,
  output logic                          o_done,
  output logic                          o_busy,
  output logic [TIMER_WIDTH-1:0]        o_elapsed,
  output logic [WINDOW_COUNT_WIDTH-1:0] o_window_count
);

  localparam logic [WINDOW_COUNT_WIDTH-1:0] WINDOW_COUNT_MAX = '1;

  pzcorebus_monitor_window_state state_q;
  logic                          periodic_q;
  logic                          done_q;
  logic [WINDOW_COUNT_WIDTH-1:0] window_count_q;

  logic                          accept_c;
  logic                          run_exit_c;
  logic                          restart_c;
  logic                          timer_clear_c;
  logic                          timer_inc_c;
  logic                          timer_terminal_c;
  logic [WINDOW_COUNT_WIDTH-1:0] window_count_inc_c;

  // Transition decisions shared by the FSM register and the timer controls.
  always_comb begin
    accept_c   = 1'b0;
    run_exit_c = 1'b0;
    restart_c  = 1'b0;
    case (state_q)
      WIN_IDLE:     accept_c   = i_start & ~i_stop;
      WIN_RUN:      run_exit_c = i_stop | timer_terminal_c;
      WIN_SNAPSHOT: restart_c  = ~done_q & periodic_q & ~i_stop;
      default:      ;
    endcase
    timer_clear_c      = accept_c | restart_c;
    timer_inc_c        = (state_q == WIN_RUN) & ~run_exit_c;
    window_count_inc_c = (window_count_q == WINDOW_COUNT_MAX) ? window_count_q
                       : window_count_q + WINDOW_COUNT_WIDTH'(1);
  end

  pzcorebus_monitor_window_timer #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_timer (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_load          (accept_c),
    .i_window_cycles (i_window_cycles),
    .i_clear         (timer_clear_c),
    .i_enable        (timer_inc_c),
    .o_count         (o_elapsed),
    .o_terminal_c    (timer_terminal_c)
  );

  // done_q marks the snapshot that ends the sequence; the count updates on
  // entry to SNAPSHOT so it already includes the strobe being issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= WIN_IDLE;
      periodic_q     <= 1'b0;
      done_q         <= 1'b0;
      window_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WIN_IDLE: begin
          if (accept_c) begin
            state_q        <= WIN_CLEAR;
            periodic_q     <= i_periodic;
            window_count_q <= '0;
          end
        end
        WIN_CLEAR: begin
          if (i_stop) begin
            state_q        <= WIN_SNAPSHOT;
            done_q         <= 1'b1;
            window_count_q <= window_count_inc_c;
          end else begin
            state_q <= WIN_RUN;
          end
        end
        WIN_RUN: begin
          if (run_exit_c) begin
            state_q        <= WIN_SNAPSHOT;
            done_q         <= i_stop | ~periodic_q;
            window_count_q <= window_count_inc_c;
          end
        end
        WIN_SNAPSHOT: begin
          state_q <= restart_c ? WIN_CLEAR : WIN_IDLE;
        end
        default: begin
          state_q <= WIN_IDLE;
        end
      endcase
    end
  end

  assign o_clear        = (state_q == WIN_CLEAR);
  assign o_enable       = (state_q == WIN_RUN);
  assign o_snapshot     = (state_q == WIN_SNAPSHOT);
  assign o_busy         = (state_q != WIN_IDLE);
  // A stop landing on a periodic snapshot makes that snapshot the final one.
  assign o_done         = done_q | (o_snapshot & i_stop);
  assign o_window_count = window_count_q;

endmodule
